// File: rtl/serial_pkg.sv
// Shared constants, FSM state encoding and frame-length helper for the serial receiver.
package serial_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_e;

    // Start + data + optional parity + stop.
    function automatic int unsigned frame_bits(input int unsigned data_w,
                                               input int unsigned parity_mode);
        return data_w + 32'd2 + 32'(parity_mode != PARITY_NONE);
    endfunction

endpackage

// File: rtl/serial_rx_frame_if.sv
// Word delivery port of the serial receiver: held word and status behind valid/ready.
interface serial_rx_frame_if #(
    parameter int unsigned DATA_W = 7
);
    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic              ready_in;
    logic              parity_err;
    logic              frame_err;
    logic              overrun;

    modport master (output data_out, valid, parity_err, frame_err, overrun,
                    input  ready_in);
    modport slave  (input  data_out, valid, parity_err, frame_err, overrun,
                    output ready_in);
endinterface

// File: rtl/rx_bit_timer.sv
// Bit-period counter: restarted on the start edge, strobes mid-bit once per bit period.
module rx_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_c,
    output logic sample_c
);
    localparam int unsigned HALF  = (CLKS_PER_BIT - 1) / 2;
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_eff;

    // The restart cycle itself counts as phase 0 of the start bit.
    always_comb begin
        cnt_eff  = restart_c ? '0 : cnt_q;
        sample_c = (cnt_eff == CNT_W'(HALF));
        cnt_d    = (cnt_eff == CNT_W'(CLKS_PER_BIT - 1)) ? '0 : cnt_eff + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/serial_rx_frame.sv
// Serial frame receiver: mid-bit sampling FSM feeding a valid/ready output register with overrun flagging.
module serial_rx_frame
    import serial_pkg::*;
#(
    parameter int unsigned DATA_W       = 7,
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned PARITY_MODE  = PARITY_EVEN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               serial_in,
    output logic               busy,
    serial_rx_frame_if.master  rx_if
);
    localparam int unsigned HALF       = (CLKS_PER_BIT - 1) / 2;
    localparam int unsigned IDX_W      = $clog2(DATA_W + 1);
    localparam bit          HAS_PARITY = (PARITY_MODE != PARITY_NONE);

    rx_state_e         state_q, state_d;
    logic              sample_c, restart_c, done_c, accept_c, perr_c;
    logic [DATA_W-1:0] shift_q, shift_d, data_q, data_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              par_bit_q, par_bit_d;
    logic              valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
    logic              ovr_q, ovr_d, busy_q, busy_d;

    assign restart_c = (state_q == ST_IDLE) && !serial_in;

    rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .restart_c (restart_c),
        .sample_c  (sample_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // With HALF=0 the start sample is the idle-detect sample itself, so START is skipped.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (!serial_in) state_d = (HALF == 0) ? ST_DATA : ST_START;
            ST_START:  if (sample_c) state_d = serial_in ? ST_IDLE : ST_DATA;
            ST_DATA:   if (sample_c && (idx_q == IDX_W'(DATA_W - 1)))
                           state_d = HAS_PARITY ? ST_PARITY : ST_STOP;
            ST_PARITY: if (sample_c) state_d = ST_STOP;
            ST_STOP:   if (sample_c) state_d = serial_in ? ST_IDLE : ST_BREAK;
            ST_BREAK:  if (serial_in) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        shift_d   = shift_q;
        idx_d     = idx_q;
        par_bit_d = par_bit_q;
        done_c    = 1'b0;
        case (state_q)
            ST_IDLE:   idx_d = '0;
            ST_DATA:   if (sample_c) begin
                           shift_d = (shift_q << 1) | DATA_W'(serial_in);
                           idx_d   = idx_q + IDX_W'(1);
                       end
            ST_PARITY: if (sample_c) par_bit_d = serial_in;
            ST_STOP:   done_c = sample_c;
            default:   ;
        endcase

        perr_c = 1'b0;
        if (PARITY_MODE == PARITY_EVEN)     perr_c = ^shift_q ^ par_bit_q;
        else if (PARITY_MODE == PARITY_ODD) perr_c = ~(^shift_q ^ par_bit_q);

        // A completing frame always wins the holding register; overrun only if the old word was not taken.
        accept_c = valid_q && rx_if.ready_in;
        data_d   = data_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        valid_d  = valid_q && !rx_if.ready_in;
        ovr_d    = ovr_q && !accept_c;
        if (done_c) begin
            data_d  = shift_q;
            perr_d  = perr_c;
            ferr_d  = !serial_in;
            valid_d = 1'b1;
            ovr_d   = valid_q && !rx_if.ready_in;
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q   <= '0;
            idx_q     <= '0;
            par_bit_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            par_bit_q <= par_bit_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            busy_q    <= busy_d;
        end
    end

    assign rx_if.data_out   = data_q;
    assign rx_if.valid      = valid_q;
    assign rx_if.parity_err = perr_q;
    assign rx_if.frame_err  = ferr_q;
    assign rx_if.overrun    = ovr_q;
    assign busy             = busy_q;
endmodule

// File: tb/tb_serial_rx_frame.sv
// Bench for serial_rx_frame: 7-bit 1-clk/bit receivers (even and odd parity) on one line, 8-bit 4-clk/bit no-parity on another.
module tb_serial_rx_frame;
    import serial_pkg::*;

    localparam int AW = 7, AN = 1, BW = 8, BN = 4;
    localparam int HALF_A = (AN - 1) / 2;
    localparam int HALF_B = (BN - 1) / 2;
    // Cycles from the start-bit cycle to the first cycle valid is seen.
    localparam int LAT_A = int'(frame_bits(32'(AW), PARITY_EVEN)) * AN - AN + HALF_A + 1;
    localparam int LAT_B = int'(frame_bits(32'(BW), PARITY_NONE)) * BN - BN + HALF_B + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sa = 1'b1, sb = 1'b1;
    logic ready_a = 1'b1, ready_b = 1'b1;
    logic busy_a, busy_b, busy_c;

    int vectors = 0, miscompares = 0, cyc = 0;
    int rise_a = -1, rise_b = -1, rise_c = -1, nrise_b = 0;
    logic pva = 1'b0, pvb = 1'b0, pvc = 1'b0;
    logic [BW-1:0] cap_b = '0;
    logic cap_pe_b = 1'b0, cap_fe_b = 1'b0, cap_ov_b = 1'b0;

    always #5 clk = ~clk;

    serial_rx_frame_if #(.DATA_W(AW)) if_a ();
    serial_rx_frame_if #(.DATA_W(AW)) if_c ();
    serial_rx_frame_if #(.DATA_W(BW)) if_b ();
    assign if_a.ready_in = ready_a;
    assign if_c.ready_in = ready_a;
    assign if_b.ready_in = ready_b;

    serial_rx_frame #(.DATA_W(AW), .CLKS_PER_BIT(AN), .PARITY_MODE(PARITY_EVEN)) dut_a (
        .clk(clk), .rst(rst), .serial_in(sa), .busy(busy_a), .rx_if(if_a.master));
    serial_rx_frame #(.DATA_W(AW), .CLKS_PER_BIT(AN), .PARITY_MODE(PARITY_ODD)) dut_c (
        .clk(clk), .rst(rst), .serial_in(sa), .busy(busy_c), .rx_if(if_c.master));
    serial_rx_frame #(.DATA_W(BW), .CLKS_PER_BIT(BN), .PARITY_MODE(PARITY_NONE)) dut_b (
        .clk(clk), .rst(rst), .serial_in(sb), .busy(busy_b), .rx_if(if_b.master));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample just after the edge and log valid rising edges.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (if_a.valid && !pva) rise_a = cyc;
        if (if_c.valid && !pvc) rise_c = cyc;
        if (if_b.valid && !pvb) begin
            rise_b = cyc;
            nrise_b++;
        end
        if (if_b.valid) begin
            cap_b    = if_b.data_out;
            cap_pe_b = if_b.parity_err;
            cap_fe_b = if_b.frame_err;
            cap_ov_b = if_b.overrun;
        end
        pva = if_a.valid;
        pvc = if_c.valid;
        pvb = if_b.valid;
    endtask

    // Reference parity check: total ones over data+parity must be even (even mode) or odd (odd mode).
    function automatic logic pe_model(input logic [31:0] w, input logic p, input int unsigned mode);
        int ones;
        ones = $countones(w) + int'(p);
        if (mode == PARITY_NONE) return 1'b0;
        return (mode == PARITY_EVEN) ? (ones % 2 == 1) : (ones % 2 == 0);
    endfunction

    task automatic send_a(input logic [AW-1:0] w, input logic p, input logic stop,
                          input int rdy_at_stop, output int t0);
        t0 = cyc;
        sa = 1'b0;
        tick();
        for (int i = AW - 1; i >= 0; i--) begin
            sa = w[i];
            tick();
        end
        sa = p;
        tick();
        sa = stop;
        if (rdy_at_stop >= 0) ready_a = rdy_at_stop[0];
        tick();
        sa = 1'b1;
    endtask

    // Noisy frames randomise every data-bit cycle except the mid-bit sample cycle.
    task automatic send_b(input logic [BW-1:0] w, input int stop_low, input bit noisy, output int t0);
        logic [BW+1:0] fr;
        fr = {1'b0, w, 1'b1};
        t0 = cyc;
        for (int k = BW + 1; k >= 0; k--) begin
            for (int c = 0; c < BN; c++) begin
                sb = fr[k];
                if (noisy && c != HALF_B && k != BW + 1 && k != 0) sb = 1'($urandom);
                if (k == 0 && stop_low > 0) sb = 1'b0;
                tick();
            end
        end
        if (stop_low > 1) begin
            sb = 1'b0;
            repeat ((stop_low - 1) * BN) tick();
        end
        sb = 1'b1;
    endtask

    task automatic check_a(input string tag, input int t0, input logic [AW-1:0] w,
                           input logic pe_e, input logic pe_o, input logic fe);
        chk({tag, " rise"}, 64'(rise_a), 64'(t0 + LAT_A));
        chk({tag, " valid"}, 64'(if_a.valid), 64'(1));
        chk({tag, " data"}, 64'(if_a.data_out), 64'(w));
        chk({tag, " perr_even"}, 64'(if_a.parity_err), 64'(pe_e));
        chk({tag, " ferr"}, 64'(if_a.frame_err), 64'(fe));
        chk({tag, " ovr"}, 64'(if_a.overrun), 64'(0));
        chk({tag, " rise_odd"}, 64'(rise_c), 64'(t0 + LAT_A));
        chk({tag, " data_odd"}, 64'(if_c.data_out), 64'(w));
        chk({tag, " perr_odd"}, 64'(if_c.parity_err), 64'(pe_o));
    endtask

    task automatic check_b(input string tag, input int t0, input logic [BW-1:0] w, input logic fe);
        chk({tag, " rise"}, 64'(rise_b), 64'(t0 + LAT_B));
        chk({tag, " data"}, 64'(cap_b), 64'(w));
        chk({tag, " perr"}, 64'(cap_pe_b), 64'(0));
        chk({tag, " ferr"}, 64'(cap_fe_b), 64'(fe));
        chk({tag, " ovr"}, 64'(cap_ov_b), 64'(0));
    endtask

    initial begin
        int t0, gap, nb_exp;
        logic [AW-1:0] wa;
        logic [BW-1:0] wb;
        logic pa, stop_a;
        bit need_gap;

        // Reset values
        repeat (3) tick();
        chk("rst data", 64'(if_a.data_out), 64'(0));
        chk("rst valid", 64'(if_a.valid), 64'(0));
        chk("rst perr", 64'(if_a.parity_err), 64'(0));
        chk("rst ferr", 64'(if_a.frame_err), 64'(0));
        chk("rst ovr", 64'(if_a.overrun), 64'(0));
        chk("rst busy", 64'({busy_a, busy_b, busy_c}), 64'(0));
        chk("rst valid_b", 64'(if_b.valid), 64'(0));
        rst = 1'b0;
        repeat (2) tick();

        // Directed 7'h53 frames, correct then wrong even parity
        send_a(7'h53, 1'b0, 1'b1, -1, t0);
        check_a("a53_p0", t0, 7'h53, 1'b0, 1'b1, 1'b0);
        chk("a53_p0 busy", 64'(busy_a), 64'(0));
        tick();
        chk("a53_p0 pulse", 64'(if_a.valid), 64'(0));
        send_a(7'h53, 1'b1, 1'b1, -1, t0);
        check_a("a53_p1", t0, 7'h53, 1'b1, 1'b0, 1'b0);

        // Random 1-clk/bit frames, some back-to-back, some with a bad stop bit
        need_gap = 1'b1;
        for (int n = 0; n < 12; n++) begin
            gap = $urandom_range(0, 2);
            if (need_gap && gap == 0) gap = 1;
            repeat (gap) tick();
            wa = AW'($urandom);
            pa = 1'($urandom);
            stop_a = ($urandom_range(0, 3) != 0);
            send_a(wa, pa, stop_a, -1, t0);
            check_a("a_rnd", t0, wa, pe_model(32'(wa), pa, PARITY_EVEN),
                    pe_model(32'(wa), pa, PARITY_ODD), !stop_a);
            need_gap = !stop_a;
        end
        repeat (2) tick();

        // Start glitch on the 4-clk/bit line
        nb_exp = nrise_b;
        sb = 1'b0;
        tick();
        sb = 1'b1;
        chk("b_glitch busy_hi", 64'(busy_b), 64'(1));
        tick();
        chk("b_glitch busy_lo", 64'(busy_b), 64'(0));
        repeat (6) tick();
        chk("b_glitch no_valid", 64'(nrise_b), 64'(nb_exp));

        send_b(8'hA5, 0, 1'b0, t0);
        nb_exp++;
        check_b("bA5", t0, 8'hA5, 1'b0);
        chk("bA5 pulse", 64'(if_b.valid), 64'(0));

        // Random frames with noise outside the sample cycle
        for (int n = 0; n < 6; n++) begin
            repeat ($urandom_range(0, 2)) tick();
            wb = BW'($urandom);
            send_b(wb, 0, 1'b1, t0);
            nb_exp++;
            check_b("b_noisy", t0, wb, 1'b0);
        end

        // Break: stop held low three bit times
        send_b(8'h00, 3, 1'b0, t0);
        nb_exp++;
        check_b("b_break", t0, 8'h00, 1'b1);
        chk("b_break busy_hold", 64'(busy_b), 64'(1));
        tick();
        chk("b_break busy_rel", 64'(busy_b), 64'(0));
        send_b(8'h3C, 0, 1'b0, t0);
        nb_exp++;
        check_b("b3C", t0, 8'h3C, 1'b0);
        chk("b frame_count", 64'(nrise_b), 64'(nb_exp));

        // Overrun with consumer stalled
        ready_a = 1'b0;
        send_a(7'h11, 1'b0, 1'b1, -1, t0);
        chk("ovr first valid", 64'(if_a.valid), 64'(1));
        chk("ovr first ovr", 64'(if_a.overrun), 64'(0));
        repeat (3) tick();
        chk("ovr hold data", 64'(if_a.data_out), 64'(7'h11));
        chk("ovr hold valid", 64'(if_a.valid), 64'(1));
        send_a(7'h22, 1'b0, 1'b1, -1, t0);
        chk("ovr second valid", 64'(if_a.valid), 64'(1));
        chk("ovr second data", 64'(if_a.data_out), 64'(7'h22));
        chk("ovr second ovr", 64'(if_a.overrun), 64'(1));
        ready_a = 1'b1;
        tick();
        chk("ovr accept valid", 64'(if_a.valid), 64'(0));
        chk("ovr accept ovr", 64'(if_a.overrun), 64'(0));

        // Acceptance in the completion cycle: no overrun
        ready_a = 1'b0;
        send_a(7'h11, 1'b0, 1'b1, -1, t0);
        send_a(7'h22, 1'b0, 1'b1, 1, t0);
        chk("sim valid", 64'(if_a.valid), 64'(1));
        chk("sim data", 64'(if_a.data_out), 64'(7'h22));
        chk("sim ovr", 64'(if_a.overrun), 64'(0));
        tick();
        chk("sim accept valid", 64'(if_a.valid), 64'(0));

        // Asynchronous reset with a held word and a frame in progress
        ready_a = 1'b0;
        wa = 7'h2A;
        send_a(wa, ^wa, 1'b1, -1, t0);
        chk("rst2 pre valid", 64'(if_a.valid), 64'(1));
        sb = 1'b0;
        repeat (BN) tick();
        sb = 1'b1;
        repeat (2 * BN) tick();
        chk("rst2 pre busy_b", 64'(busy_b), 64'(1));
        #3;
        rst = 1'b1;
        #1;
        chk("rst2 data", 64'(if_a.data_out), 64'(0));
        chk("rst2 valid", 64'(if_a.valid), 64'(0));
        chk("rst2 flags", 64'({if_a.parity_err, if_a.frame_err, if_a.overrun}), 64'(0));
        chk("rst2 busy", 64'({busy_a, busy_b, busy_c}), 64'(0));
        ready_a = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
        send_b(8'h7F, 0, 1'b0, t0);
        check_b("b7F", t0, 8'h7F, 1'b0);
        send_a(7'h7F, 1'b1, 1'b1, -1, t0);
        check_a("a7F", t0, 7'h7F, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/serial_rx_frame.md
Name: serial_rx_frame

Overview:
Parametrised serial frame receiver for the serial link: start bit, DATA_W data bits MSB-first, optional parity bit, one stop bit.
- Adds programmable bit period with mid-bit sampling, start-glitch rejection, selectable parity mode and stop-bit framing check.
- Each received word is held in an output register behind a valid/ready handshake, with overrun reporting.
- Sits between the serial pin and the consumer logic.

Parameters:
DATA_W, 7, data bits per frame (1..32)
CLKS_PER_BIT, 1, clock cycles per serial bit (>=1); 1 means one bit per clock
PARITY_MODE, 1, 0 = none (no parity bit), 1 = even, 2 = odd

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
serial_in  in  1  serial line, idle high
data_out  out  DATA_W  received word, MSB = first data bit on the line
valid  out  1  data_out and status flags hold an unread word
ready_in  in  1  consumer accepts the word when valid && ready_in
parity_err  out  1  parity mismatch for the held word (always 0 when PARITY_MODE=0)
frame_err  out  1  stop bit of the held word sampled 0
overrun  out  1  held word replaced an unread word
busy  out  1  frame reception in progress (state != IDLE)

Behaviour:
- Reset (async, rst=1): state IDLE; data_out=0; valid=0; parity_err=0; frame_err=0; overrun=0; busy=0. A partial frame in progress is discarded.
- Notation: P=1 if PARITY_MODE!=0, else 0; HALF=(CLKS_PER_BIT-1)/2 (floor); t0 = the cycle in which IDLE samples serial_in=0.
- Sample points: frame bit k (0 = start, 1..DATA_W = data, DATA_W+1 = parity if P=1, last = stop) is sampled at t0 + k*CLKS_PER_BIT + HALF.
  - With CLKS_PER_BIT=1, the start bit is the t0 sample and data bit i is sampled at t0+1+i.
- States:
  - IDLE -> START on serial_in=0.
  - START -> DATA if the start sample is 0. If the sample is 1, this is a glitch and the FSM returns to IDLE; nothing is reported.
  - DATA: shift left, LSB-in, DATA_W samples -> PARITY (P=1) or STOP.
  - PARITY: one sample -> STOP.
  - STOP: one sample -> IDLE if 1; -> BREAK if 0.
  - BREAK: wait for serial_in=1, then IDLE. No start detection is performed in BREAK.
- Parity: even -> parity_err = ^data ^ p; odd -> parity_err = ~(^data ^ p).
- Completion (cycle of the stop sample):
  - Next cycle: data_out, parity_err, frame_err load and valid=1.
  - Frames with errors are still delivered, with their flags set.
- Handshake:
  - valid stays high until a cycle with ready_in=1; the next cycle has valid=0 unless a new word loads.
  - data_out and flags are stable while valid=1 and no new word completes.
- Overrun: a completion while valid=1 and ready_in=0 overwrites data_out/flags and sets overrun=1 for the new word. overrun clears with that word's acceptance.
- Simultaneous completion and acceptance: the old word is consumed, the new word loads, valid stays 1, overrun=0.
- Reception never stalls on the consumer. The sampling path is independent of valid/ready_in.
- busy=1 from the cycle after t0 until the FSM re-enters IDLE.

Decomposition:
- Package serial_pkg: PARITY_NONE/EVEN/ODD constants, state encoding (IDLE, START, DATA, PARITY, STOP, BREAK), frame-length helper DATA_W+2+P.
- Sub-module rx_bit_timer: CLKS_PER_BIT counter.
  - Restarted at t0.
  - Emits a one-cycle sample strobe at HALF, then every CLKS_PER_BIT cycles.
  - Main FSM samples only on the strobe.

Test Plan:
- DATA_W=7, N=1, even, ready_in=1: line 0,1010011,p=0,1 -> valid pulse 1 cycle, 1 cycle after the stop sample, data_out=7'h53, parity_err=0, frame_err=0.
- Same frame with p=1 -> data_out=7'h53, parity_err=1. PARITY_MODE=2 with p=1 -> parity_err=0.
- N=4, DATA_W=8, none: frame 0x A5 at 4 clocks/bit, plus a 1-cycle low glitch on an idle line -> glitch ignored (busy drops, no valid); word 8'hA5 delivered; samples land on cycle 1 of each bit.
- Stop bit held 0 for 3 bit times -> frame_err=1. No new frame starts until the line returns high, then 0x3C is received cleanly.
- ready_in=0, two back-to-back frames 0x11, 0x22 -> data_out=0x22 with overrun=1; ready_in=1 -> valid=0, overrun=0. Repeat with ready_in=1 in the completion cycle -> overrun=0.
- rst asserted mid-DATA -> all outputs 0 immediately; after release, a fresh frame 0x7F is received correctly.
